wbu_multi_port: RTL and testbench

- Parametrised successor to the single-input writeback stage. Merges NCH independent producer channels into the one integer register-file write port. Typical producers: the memory stage, the multi-cycle mul/div unit and the CSR unit.
- Each channel is buffered in its own DEPTH-entry FIFO. A round-robin arbiter picks one FIFO head per cycle into the WB register. Register-file write, forwarding bus, retire debug signals and a retired-instruction counter are driven from that register.

---
 rtl/wbu_multi_port_pkg.sv | 23 ++
 rtl/wbu_multi_port_fifo.sv | 47 ++++
 rtl/wbu_multi_port.sv | 138 +++++++++++++
 tb/tb_wbu_multi_port.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbu_multi_port_pkg.sv
// rtl/wbu_multi_port_pkg.sv - shared widths and writeback bus layout for the multi-port writeback stage
package wbu_multi_port_pkg;

    localparam int WBU_XLEN    = 64;
    localparam int WBU_ADDR_WD = 5;
    localparam int WBU_PC_WD   = 64;

    // Producer bus is packed {we, rd, wdata, pc}, pc in the low bits
    localparam int WBU_BUS_WD    = 1 + WBU_ADDR_WD + WBU_XLEN + WBU_PC_WD;
    localparam int WBU_PC_LSB    = 0;
    localparam int WBU_WDATA_LSB = WBU_PC_LSB + WBU_PC_WD;
    localparam int WBU_RD_LSB    = WBU_WDATA_LSB + WBU_XLEN;
    localparam int WBU_WE_BIT    = WBU_RD_LSB + WBU_ADDR_WD;

    // Forwarding bus is {fwd_valid, wdata, rd}
    localparam int WBU_FWD_BUS_WD = 1 + WBU_XLEN + WBU_ADDR_WD;

    // Channel-index width; a single channel still needs one bit
    function automatic int src_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/wbu_multi_port_fifo.sv
// rtl/wbu_multi_port_fifo.sv - per-channel synchronous FIFO with wrap-bit pointers
module wbu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers advance independently; simultaneous push and pop keeps occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/wbu_multi_port.sv
// rtl/wbu_multi_port.sv - round-robin merge of NCH producer channels into one register-file write port
module wbu_multi_port
    import wbu_multi_port_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int DEPTH   = 2,
    parameter int XLEN    = WBU_XLEN,
    parameter int ADDR_WD = WBU_ADDR_WD,
    parameter int PC_WD   = WBU_PC_WD,
    parameter int CNT_WD  = 64
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NCH-1:0]                               in_valid,
    output logic [NCH-1:0]                               in_allowin,
    input  logic [NCH*(1+ADDR_WD+XLEN+PC_WD)-1:0]        in_bus,
    output logic                                         rf_we,
    output logic [ADDR_WD-1:0]                           rf_waddr,
    output logic [XLEN-1:0]                              rf_wdata,
    output logic [XLEN+ADDR_WD:0]                        fwd_bus,
    output logic                                         wb_valid,
    output logic [PC_WD-1:0]                             wb_pc,
    output logic [src_width(NCH)-1:0]                    wb_src,
    output logic [CNT_WD-1:0]                            instret
);

    localparam int BUS_WD    = 1 + ADDR_WD + XLEN + PC_WD;
    localparam int SRC_WD    = src_width(NCH);
    localparam int WDATA_LSB = PC_WD;
    localparam int RD_LSB    = PC_WD + XLEN;

    logic [NCH-1:0]    full;
    logic [NCH-1:0]    empty;
    logic [NCH-1:0]    push;
    logic [NCH-1:0]    pop;
    logic [BUS_WD-1:0] head [NCH];

    logic              grant;
    logic [SRC_WD-1:0] gnt_idx;
    logic [SRC_WD-1:0] rr_ptr;
    logic [SRC_WD-1:0] rr_next;
    int                scan_idx;

    logic              ws_valid;
    logic [BUS_WD-1:0] ws_bus;
    logic [SRC_WD-1:0] ws_src;

    logic               ws_we;
    logic [ADDR_WD-1:0] ws_rd;
    logic [XLEN-1:0]    ws_wdata;
    logic [PC_WD-1:0]   ws_pc;

    // Acceptance looks only at registered fullness, never at a same-cycle pop
    assign in_allowin = ~full;
    assign push       = in_valid & ~full;

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            wbu_fifo #(
                .WIDTH (BUS_WD),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (push[c]),
                .pop   (pop[c]),
                .din   (in_bus[c*BUS_WD +: BUS_WD]),
                .dout  (head[c]),
                .full  (full[c]),
                .empty (empty[c])
            );
        end
    endgenerate

    // Round-robin scan from rr_ptr; walking backwards lets the nearest non-empty channel win
    always_comb begin
        grant    = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            scan_idx = (int'(rr_ptr) + i) % NCH;
            if (!empty[scan_idx]) begin
                grant   = 1'b1;
                gnt_idx = SRC_WD'(scan_idx);
            end
        end
    end

    // One-hot pop of the granted head; the stage never stalls
    always_comb begin
        pop = '0;
        if (grant) pop[gnt_idx] = 1'b1;
    end

    assign rr_next = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;

    // WB register: load the granted head, otherwise drop valid and hold the data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_valid <= 1'b0;
            ws_bus   <= '0;
            ws_src   <= '0;
            rr_ptr   <= '0;
        end else begin
            ws_valid <= grant;
            if (grant) begin
                ws_bus <= head[gnt_idx];
                ws_src <= gnt_idx;
                rr_ptr <= rr_next;
            end
        end
    end

    // Retired-instruction counter, wraps freely
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= '0;
        end else if (ws_valid) begin
            instret <= instret + 1'b1;
        end
    end

    assign ws_we    = ws_bus[BUS_WD-1];
    assign ws_rd    = ws_bus[RD_LSB +: ADDR_WD];
    assign ws_wdata = ws_bus[WDATA_LSB +: XLEN];
    assign ws_pc    = ws_bus[PC_WD-1:0];

    // Writes to x0 retire but never reach the register file or the forwarding bus
    assign rf_we    = ws_valid && ws_we && (ws_rd != '0);
    assign rf_waddr = ws_rd;
    assign rf_wdata = ws_wdata;
    assign fwd_bus  = {rf_we, ws_wdata, ws_rd};
    assign wb_valid = ws_valid;
    assign wb_pc    = ws_pc;
    assign wb_src   = ws_src;

endmodule

// File: tb/tb_wbu_multi_port.sv
// tb/tb_wbu_multi_port.sv - randomized bench with queue-based reference model for wbu_multi_port
module tb_wbu_multi_port;

    localparam int NCH     = 2;
    localparam int DEPTH   = 2;
    localparam int XLEN    = 64;
    localparam int ADDR_WD = 5;
    localparam int PC_WD   = 64;
    localparam int CNT_WD  = 4;
    localparam int BUS_WD  = 1 + ADDR_WD + XLEN + PC_WD;
    localparam int FWD_WD  = 1 + XLEN + ADDR_WD;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NCH-1:0]          in_valid = '0;
    logic [NCH-1:0]          in_allowin;
    logic [NCH*BUS_WD-1:0]   in_bus = '0;
    logic                    rf_we;
    logic [ADDR_WD-1:0]      rf_waddr;
    logic [XLEN-1:0]         rf_wdata;
    logic [FWD_WD-1:0]       fwd_bus;
    logic                    wb_valid;
    logic [PC_WD-1:0]        wb_pc;
    logic [0:0]              wb_src;
    logic [CNT_WD-1:0]       instret;

    wbu_multi_port #(
        .NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN), .ADDR_WD(ADDR_WD), .PC_WD(PC_WD), .CNT_WD(CNT_WD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_allowin (in_allowin),
        .in_bus     (in_bus),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .fwd_bus    (fwd_bus),
        .wb_valid   (wb_valid),
        .wb_pc      (wb_pc),
        .wb_src     (wb_src),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BUS_WD-1:0] mk(input logic we, input logic [ADDR_WD-1:0] rd,
                                             input logic [XLEN-1:0] wd, input logic [PC_WD-1:0] pc);
        return {we, rd, wd, pc};
    endfunction

    function automatic logic [BUS_WD-1:0] rand_entry();
        logic [XLEN-1:0]  wd;
        logic [PC_WD-1:0] pc;
        wd = {$urandom, $urandom};
        pc = {$urandom, $urandom};
        return mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), wd, pc);
    endfunction

    // Reference model: one queue per channel, a pointer, and the retiring entry
    logic [BUS_WD-1:0] mq [NCH][$];
    bit                m_valid;
    logic [BUS_WD-1:0] m_bus;
    int                m_src;
    int                m_rr;
    logic [CNT_WD-1:0] m_cnt;
    int                m_sz [NCH];
    int                m_g;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_valid = 0;
            m_bus   = '0;
            m_src   = 0;
            m_rr    = 0;
            m_cnt   = '0;
        end else begin
            for (int c = 0; c < NCH; c++) m_sz[c] = mq[c].size();
            if (m_valid) m_cnt = m_cnt + 1'b1;
            m_g = -1;
            for (int i = 0; i < NCH; i++) begin
                int ch;
                ch = (m_rr + i) % NCH;
                if (m_g < 0 && m_sz[ch] > 0) m_g = ch;
            end
            if (m_g >= 0) begin
                m_bus   = mq[m_g].pop_front();
                m_valid = 1;
                m_src   = m_g;
                m_rr    = (m_g + 1) % NCH;
            end else begin
                m_valid = 0;
            end
            for (int c = 0; c < NCH; c++)
                if (in_valid[c] && m_sz[c] < DEPTH) mq[c].push_back(in_bus[c*BUS_WD +: BUS_WD]);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic               e_we;
        logic [ADDR_WD-1:0] e_rd;
        logic [XLEN-1:0]    e_wd;
        logic [NCH-1:0]     e_allow;
        e_rd = m_bus[PC_WD+XLEN +: ADDR_WD];
        e_wd = m_bus[PC_WD +: XLEN];
        e_we = m_valid && m_bus[BUS_WD-1] && (e_rd != 0);
        for (int c = 0; c < NCH; c++) e_allow[c] = (mq[c].size() < DEPTH);
        check("allowin",  in_allowin, e_allow);
        check("rf_we",    rf_we, e_we);
        check("rf_waddr", rf_waddr, e_rd);
        check("rf_wdata", rf_wdata, e_wd);
        check("fwd_bus",  fwd_bus, {e_we, e_wd, e_rd});
        check("wb_valid", wb_valid, m_valid);
        check("wb_pc",    wb_pc, m_bus[PC_WD-1:0]);
        check("wb_src",   wb_src, m_src);
        check("instret",  instret, m_cnt);
    end

    // Retirement monitor for the scenario-level checks
    int   ret_cnt [NCH];
    bit   log_en = 0;
    int   src_log [$];
    bit   saw_full0 = 0;

    initial for (int c = 0; c < NCH; c++) ret_cnt[c] = 0;

    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            ret_cnt[wb_src]++;
            if (log_en) src_log.push_back(int'(wb_src));
        end
        if (!reset && !in_allowin[0]) saw_full0 = 1;
    end

    // Producers that hold valid and data until accepted; called at posedge+1
    task automatic produce(input int n0, input int n1, input bit gaps);
        int                left [NCH];
        bit                hold [NCH];
        logic [BUS_WD-1:0] b [NCH];
        logic [NCH-1:0]    acc;
        int                cyc;
        left[0] = n0; left[1] = n1;
        hold[0] = 0;  hold[1] = 0;
        b[0] = '0;    b[1] = '0;
        cyc = 0;
        while ((left[0] > 0 || left[1] > 0 || hold[0] || hold[1]) && cyc < 2000) begin
            for (int c = 0; c < NCH; c++) begin
                if (!hold[c] && left[c] > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                    hold[c] = 1;
                    left[c]--;
                    b[c] = rand_entry();
                end
            end
            in_valid = {hold[1], hold[0]};
            in_bus   = {b[1], b[0]};
            @(negedge clk);
            acc = in_valid & in_allowin;
            @(posedge clk);
            #1;
            for (int c = 0; c < NCH; c++) if (acc[c]) hold[c] = 0;
            cyc++;
        end
        in_valid = '0;
        check("produce_done", cyc < 2000, 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((mq[0].size() > 0 || mq[1].size() > 0 || m_valid) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_done", k < 100, 1'b1);
    endtask

    int r0, r1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("rst_allowin",  in_allowin, 2'b11);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_instret",  instret, 4'd0);
        check("rst_rf_wdata", rf_wdata, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single channel latency
        in_valid = 2'b01;
        in_bus[0 +: BUS_WD] = mk(1'b1, 5'd5, 64'h1234, 64'h8000_0000);
        @(posedge clk);
        #1;
        in_valid = '0;
        @(negedge clk);
        check("no_bypass", wb_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("single_rf_we",    rf_we, 1'b1);
        check("single_rf_waddr", rf_waddr, 5'd5);
        check("single_rf_wdata", rf_wdata, 64'h1234);
        check("single_wb_pc",    wb_pc, 64'h8000_0000);
        check("single_fwd_v",    fwd_bus[FWD_WD-1], 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("single_instret", instret, 4'd1);
        @(posedge clk);
        #1;

        // x0 write on channel 1
        in_valid = 2'b10;
        in_bus[BUS_WD +: BUS_WD] = mk(1'b1, 5'd0, 64'hFFFF, 64'h8000_0004);
        @(posedge clk);
        #1;
        in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check("x0_rf_we",    rf_we, 1'b0);
        check("x0_fwd_v",    fwd_bus[FWD_WD-1], 1'b0);
        check("x0_wb_valid", wb_valid, 1'b1);
        check("x0_wb_src",   wb_src, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("x0_instret", instret, 4'd2);
        @(posedge clk);
        #1;

        // Contention: both channels, four entries each, strict alternation
        src_log.delete();
        log_en = 1;
        produce(4, 4, 0);
        drain();
        log_en = 0;
        check("contention_count", src_log.size(), 8);
        for (int i = 0; i < src_log.size(); i++) check("contention_src", src_log[i], i % 2);

        // Backpressure: both saturated for six entries
        saw_full0 = 0;
        r0 = ret_cnt[0];
        r1 = ret_cnt[1];
        produce(6, 6, 0);
        drain();
        check("bp_saw_full0", saw_full0, 1'b1);
        check("bp_ret0", ret_cnt[0] - r0, 6);
        check("bp_ret1", ret_cnt[1] - r1, 6);

        // Random traffic with gaps
        r0 = ret_cnt[0];
        r1 = ret_cnt[1];
        produce(40, 40, 1);
        drain();
        check("rand_ret0", ret_cnt[0] - r0, 40);
        check("rand_ret1", ret_cnt[1] - r1, 40);

        // Asynchronous reset with entries buffered
        produce(3, 3, 0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_allowin",  in_allowin, 2'b11);
        check("arst_wb_valid", wb_valid, 1'b0);
        check("arst_rf_we",    rf_we, 1'b0);
        check("arst_instret",  instret, 4'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_idle", wb_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Counter wrap: 17 retirements on a 4-bit counter
        produce(17, 0, 0);
        drain();
        @(negedge clk);
        check("wrap_instret", instret, 4'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
